// File: rtl/rif_rr_arbiter_pkg.sv
// rif_arb_pkg: shared state type, parameter limits and the round-robin
// grant helper used by the register-file arbiter (rif_rr_arbiter).
package rif_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int unsigned MIN_REQ        = 2;
    localparam int unsigned MAX_REQ        = 8;
    localparam int unsigned MAX_IDX_W      = 3;
    localparam int unsigned MIN_DATA_WIDTH = 8;
    localparam int unsigned MAX_DATA_WIDTH = 1024;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit data_width_ok(input int unsigned w);
        return (w >= MIN_DATA_WIDTH) && (w <= MAX_DATA_WIDTH) && is_pow2(w);
    endfunction

    // First set bit of req searching from last+1, wrapping modulo n.
    // Returns 0 when req is empty; callers qualify with |req.
    function automatic int unsigned rr_next_grant(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        last,
        input int unsigned        n
    );
        int unsigned cand;
        int unsigned idx;
        bit          found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                cand = last + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (!found && req[cand[MAX_IDX_W-1:0]]) begin
                    idx   = cand;
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rif_rr_arbiter_if.sv
// rif_rr_arbiter_if: requester handshake, response and register-file bus
// seen by the arbiter. Optional macro RIF_ARB_LOCK_EN adds req_lock.
interface rif_rr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_COUNT = DATA_WIDTH / 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*BYTE_COUNT-1:0] req_wstrb;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
`ifdef RIF_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            req_lock;
`endif
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_rdata;
    logic                          resp_err;
    logic [ADDR_WIDTH-1:0]         rif_addr;
    logic                          rif_addr_valid;
    logic                          rif_wr_req;
    logic                          rif_rd_req;
    logic [BYTE_COUNT-1:0]         rif_wstrb;
    logic [DATA_WIDTH-1:0]         rif_wdata;
    logic [DATA_WIDTH-1:0]         rif_rdata;

    // Arbiter view.
    modport slave (
`ifdef RIF_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_write, req_addr, req_wstrb, req_wdata,
        input  rif_addr_valid, rif_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata
    );

    // Requesters plus register file view.
    modport master (
`ifdef RIF_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_write, req_addr, req_wstrb, req_wdata,
        output rif_addr_valid, rif_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata
    );
endinterface

// File: rtl/rif_rr_arbiter_rr_arbiter.sv
// rr_arbiter: reusable round-robin picker. Combinational one-hot grant and
// index from a request vector; the last-winner pointer advances on 'advance'.
import rif_arb_pkg::*;

module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);
    logic [IDX_W-1:0]   last_q;
    logic [MAX_REQ-1:0] req_ext;

    // Scan from the slot after the last winner, wrapping, for the first requester.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        grant_any              = |req;
        grant_idx              = IDX_W'(rr_next_grant(req_ext, 32'(last_q), NUM_REQ));
        grant                  = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the winner only when the grant is taken; reset favours requester 0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end
endmodule

// File: rtl/rif_rr_arbiter.sv
// rif_rr_arbiter: shares one register-file interface among NUM_REQ
// requesters with round-robin arbitration; one access in flight, three
// cycles per access (accept, rif strobe, response pulse).
// Optional macro RIF_ARB_LOCK_EN: req_lock keeps the grant on one requester.
import rif_arb_pkg::*;

module rif_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    rif_rr_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < MIN_REQ || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $fatal(1, "rif_rr_arbiter: NUM_REQ must be 2..8");
    end
    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $fatal(1, "rif_rr_arbiter: DATA_WIDTH must be a power of 2 in 8..1024");
    end

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      arb_req;
    logic [NUM_REQ-1:0]      grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    accept;

    logic [IDX_W-1:0]        owner_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BYTE_COUNT-1:0]   wstrb_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [NUM_REQ-1:0]      req_ready_c;
    logic [NUM_REQ-1:0]      resp_valid_c;
    logic                    wr_req_c;
    logic                    rd_req_c;
    logic                    resp_err_c;

`ifdef RIF_ARB_LOCK_EN
    logic                    locked_q;

    // While locked and the owner is still requesting, only the owner may win.
    always_comb begin
        arb_req = bus.req_valid;
        if (locked_q && bus.req_valid[owner_q]) begin
            arb_req          = '0;
            arb_req[owner_q] = 1'b1;
        end
    end

    // Lock state follows req_lock of each accepted request. Taking it at accept
    // rather than at completion is equivalent: no arbitration happens in between.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            locked_q <= 1'b0;
        end else if (accept) begin
            locked_q <= bus.req_lock[grant_idx];
        end else if (state_q == IDLE && locked_q && !bus.req_valid[owner_q]) begin
            locked_q <= 1'b0;
        end
    end
`else
    assign arb_req = bus.req_valid;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (arb_req),
        .advance   (accept),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake and strobe outputs; all quiet while in reset.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        req_ready_c  = '0;
        resp_valid_c = '0;
        wr_req_c     = 1'b0;
        rd_req_c     = 1'b0;
        resp_err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any && HRESETn) begin
                    accept      = 1'b1;
                    req_ready_c = grant_oh;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                wr_req_c = write_q;
                rd_req_c = !write_q;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid_c[owner_q] = 1'b1;
                resp_err_c            = err_q;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's request fields at accept; they hold until the next accept.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            owner_q <= grant_idx;
            write_q <= bus.req_write[grant_idx];
            addr_q  <= bus.req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            wstrb_q <= bus.req_wstrb[32'(grant_idx) * BYTE_COUNT +: BYTE_COUNT];
            wdata_q <= bus.req_wdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Capture the register-file result during the strobe cycle; errors and writes return 0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            err_q   <= !bus.rif_addr_valid;
            rdata_q <= (write_q || !bus.rif_addr_valid) ? '0 : bus.rif_rdata;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_c;
    assign bus.rif_addr   = addr_q;
    assign bus.rif_wstrb  = wstrb_q;
    assign bus.rif_wdata  = wdata_q;
    assign bus.rif_wr_req = wr_req_c;
    assign bus.rif_rd_req = rd_req_c;
endmodule

// File: tb/tb_rif_rr_arbiter.sv
// tb_rif_rr_arbiter: directed and randomized checks of rif_rr_arbiter with
// three requesters against a transaction-timing reference model.
// Optional macro RIF_ARB_LOCK_EN enables the locked-sequence test.
`timescale 1ns/1ps
module tb_rif_rr_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned BC = 4;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    rif_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BC)) bus ();

    rif_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BC)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Requester / register-file stimulus.
    logic [N-1:0]  r_valid;
    logic [N-1:0]  r_write;
`ifdef RIF_ARB_LOCK_EN
    logic [N-1:0]  r_lock;
`endif
    logic [AW-1:0] r_addr  [N];
    logic [BC-1:0] r_wstrb [N];
    logic [DW-1:0] r_wdata [N];
    logic [DW-1:0] rd_data;
    logic          addr_ok;
    bit            keep_valid;

    // Reference model: an access accepted in cycle A strobes in A+1,
    // responds in A+2, and the arbiter is free again from A+3.
    int            cyc;
    int            acc_cyc;
    int            last_g;
    int            tx_g;
    logic          tx_write;
    logic [AW-1:0] tx_addr;
    logic [BC-1:0] tx_wstrb;
    logic [DW-1:0] tx_wdata;
    logic [DW-1:0] hold_rdata;
    logic          cap_err;
    bit            locked;
    int            grant_log [$];
    int            ready_cyc [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = r_valid;
        bus.req_write = r_write;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = r_addr[i];
            bus.req_wstrb[i*BC +: BC] = r_wstrb[i];
            bus.req_wdata[i*DW +: DW] = r_wdata[i];
        end
`ifdef RIF_ARB_LOCK_EN
        bus.req_lock = r_lock;
`endif
        bus.rif_rdata      = rd_data;
        bus.rif_addr_valid = addr_ok;
    endtask

    task automatic model_reset();
        acc_cyc    = -100;
        last_g     = N - 1;
        tx_g       = 0;
        tx_write   = 1'b0;
        tx_addr    = '0;
        tx_wstrb   = '0;
        tx_wdata   = '0;
        hold_rdata = '0;
        cap_err    = 1'b0;
        locked     = 1'b0;
    endtask

    // One clock cycle: entered 1ns after a rising edge with stimulus prepared.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_resp;
        logic [N-1:0] elig;
        int           g;
        drive();
        #1;
        exp_ready = '0;
        exp_resp  = '0;
        g         = -1;
        if (cyc >= acc_cyc + 3) begin
            elig = r_valid;
`ifdef RIF_ARB_LOCK_EN
            if (locked) begin
                if (r_valid[tx_g]) begin
                    elig       = '0;
                    elig[tx_g] = 1'b1;
                end else begin
                    locked = 1'b0;
                end
            end
`endif
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last_g + k) % N;
                if (g < 0 && elig[idx]) g = idx;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        if (cyc == acc_cyc + 2) exp_resp[tx_g] = 1'b1;

        check("req_ready",  bus.req_ready,  exp_ready);
        check("rif_rd_req", bus.rif_rd_req, (cyc == acc_cyc + 1) && !tx_write);
        check("rif_wr_req", bus.rif_wr_req, (cyc == acc_cyc + 1) && tx_write);
        check("rif_addr",   bus.rif_addr,   tx_addr);
        check("rif_wstrb",  bus.rif_wstrb,  tx_wstrb);
        check("rif_wdata",  bus.rif_wdata,  tx_wdata);
        check("resp_valid", bus.resp_valid, exp_resp);
        check("resp_err",   bus.resp_err,   (cyc == acc_cyc + 2) && cap_err);
        check("resp_rdata", bus.resp_rdata, hold_rdata);

        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i] === 1'b1) begin
                grant_log.push_back(i);
                ready_cyc.push_back(cyc);
            end
        end

        if (cyc == acc_cyc + 1) begin
            cap_err    = !addr_ok;
            hold_rdata = (tx_write || !addr_ok) ? '0 : rd_data;
        end
        if (g >= 0) begin
            acc_cyc  = cyc;
            last_g   = g;
            tx_g     = g;
            tx_write = r_write[g];
            tx_addr  = r_addr[g];
            tx_wstrb = r_wstrb[g];
            tx_wdata = r_wdata[g];
`ifdef RIF_ARB_LOCK_EN
            locked   = r_lock[g];
`endif
            if (!keep_valid) r_valid[g] = 1'b0;
        end
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        r_valid    = '0;
        r_write    = '0;
`ifdef RIF_ARB_LOCK_EN
        r_lock     = '0;
`endif
        for (int i = 0; i < N; i++) begin
            r_addr[i]  = AW'(16 * i + 4);
            r_wstrb[i] = 4'hF;
            r_wdata[i] = 32'h1000_0000 + i;
        end
        rd_data    = '0;
        addr_ok    = 1'b1;
        keep_valid = 1'b0;
        cyc        = 0;
        model_reset();

        // Reset state, with requests pending that must be ignored.
        HRESETn = 1'b0;
        r_valid = '1;
        drive();
        repeat (2) @(posedge HCLK);
        #2;
        check("rst_req_ready",  bus.req_ready,  0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_err",   bus.resp_err,   0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_rd_req",     bus.rif_rd_req, 0);
        check("rst_wr_req",     bus.rif_wr_req, 0);
        check("rst_rif_addr",   bus.rif_addr,   0);
        check("rst_rif_wdata",  bus.rif_wdata,  0);
        r_valid = '0;
        drive();
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Fairness: all requesters continuously valid.
        grant_log.delete();
        ready_cyc.delete();
        keep_valid = 1'b1;
        r_valid    = '1;
        for (int t = 0; t < 40 && grant_log.size() < 6; t++) step();
        keep_valid = 1'b0;
        r_valid    = '0;
        check("fair_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("fair_order", grant_log[i], i % 3);
        for (int i = 1; i < 6 && i < ready_cyc.size(); i++) check("fair_spacing", ready_cyc[i] - ready_cyc[i-1], 3);
        repeat (3) step();

        // Single read.
        r_valid[0] = 1'b1;
        r_write[0] = 1'b0;
        r_addr[0]  = 12'h010;
        rd_data    = 32'hDEADBEEF;
        addr_ok    = 1'b1;
        step();
        check("t1_rd_req",     bus.rif_rd_req, 1);
        check("t1_rif_addr",   bus.rif_addr,   12'h010);
        step();
        check("t1_resp_valid", bus.resp_valid, 3'b001);
        check("t1_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
        check("t1_resp_err",   bus.resp_err,   0);
        step();

        // Write.
        r_valid[1] = 1'b1;
        r_write[1] = 1'b1;
        r_addr[1]  = 12'h044;
        r_wstrb[1] = 4'h3;
        r_wdata[1] = 32'h12345678;
        step();
        check("t2_wr_req",     bus.rif_wr_req, 1);
        check("t2_rd_req",     bus.rif_rd_req, 0);
        check("t2_rif_addr",   bus.rif_addr,   12'h044);
        check("t2_rif_wstrb",  bus.rif_wstrb,  4'h3);
        check("t2_rif_wdata",  bus.rif_wdata,  32'h12345678);
        step();
        check("t2_wr_once",    bus.rif_wr_req, 0);
        check("t2_resp_valid", bus.resp_valid, 3'b010);
        check("t2_resp_rdata", bus.resp_rdata, 0);
        step();

        // Bad address, then a clean access.
        r_valid[2] = 1'b1;
        r_write[2] = 1'b0;
        r_addr[2]  = 12'h7FF;
        rd_data    = 32'hCAFEF00D;
        addr_ok    = 1'b0;
        step();
        step();
        check("t4_resp_valid", bus.resp_valid, 3'b100);
        check("t4_resp_err",   bus.resp_err,   1);
        check("t4_resp_rdata", bus.resp_rdata, 0);
        addr_ok    = 1'b1;
        rd_data    = 32'h0BADC0DE;
        r_valid[0] = 1'b1;
        r_write[0] = 1'b0;
        r_addr[0]  = 12'h020;
        step();
        step();
        step();
        check("t4_next_valid", bus.resp_valid, 3'b001);
        check("t4_next_err",   bus.resp_err,   0);
        check("t4_next_rdata", bus.resp_rdata, 32'h0BADC0DE);
        step();

        // Randomized traffic, including withdrawn requests and bad addresses.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        r_valid[i] = 1'b1;
                        r_write[i] = 1'($urandom_range(1));
                        r_addr[i]  = AW'($urandom);
                        r_wstrb[i] = BC'($urandom);
                        r_wdata[i] = $urandom;
                    end
                end else if ($urandom_range(19) == 0) begin
                    r_valid[i] = 1'b0;
                end
            end
            rd_data = $urandom;
            addr_ok = ($urandom_range(7) != 0);
            step();
        end

        // Reset during ACCESS.
        r_valid = '0;
        addr_ok = 1'b1;
        repeat (3) step();
        r_valid[2] = 1'b1;
        r_write[2] = 1'b0;
        r_addr[2]  = 12'h0A0;
        step();
        check("t5_rd_before", bus.rif_rd_req, 1);
        HRESETn = 1'b0;
        #1;
        check("t5_rd_drop",   bus.rif_rd_req, 0);
        check("t5_wr_drop",   bus.rif_wr_req, 0);
        check("t5_no_resp",   bus.resp_valid, 0);
        model_reset();
        r_valid = '1;
        drive();
        @(posedge HCLK);
        #1;
        check("t5_resp_held", bus.resp_valid, 0);
        check("t5_ready_rst", bus.req_ready,  0);
        HRESETn = 1'b1;
        grant_log.delete();
        step();
        check("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : 99, 0);
        r_valid = '0;
        repeat (3) step();

`ifdef RIF_ARB_LOCK_EN
        // Locked read then unlocked write from requester 1 while requester 0 waits.
        grant_log.delete();
        r_valid[1] = 1'b1;
        r_write[1] = 1'b0;
        r_lock[1]  = 1'b1;
        r_addr[1]  = 12'h100;
        step();
        r_valid[1] = 1'b1;
        r_write[1] = 1'b1;
        r_lock[1]  = 1'b0;
        r_valid[0] = 1'b1;
        r_lock[0]  = 1'b0;
        for (int t = 0; t < 20 && grant_log.size() < 3; t++) step();
        check("t6_count", grant_log.size(), 3);
        if (grant_log.size() >= 3) begin
            check("t6_grant0", grant_log[0], 1);
            check("t6_grant1", grant_log[1], 1);
            check("t6_grant2", grant_log[2], 0);
        end
        r_valid = '0;
        repeat (3) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
